// File: rtl/multiplicador_secuencial.sv
// Sequential signed fixed-point multiplier (Q(W-F).F): one shift-add step per cycle, then floor-shift and saturate.
// Latency: Start accepted at edge k -> Done pulse and new Pout after edge k+W+2. Start is ignored while busy (no queueing).
module multiplicador_secuencial #(
    parameter int W = 12,
    parameter int F = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Pout,
    output logic         Busy,
    output logic         Done
);

    localparam int CW = $clog2(W + 1);
    localparam logic signed [2*W-1:0] MAX_P = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MIN_N = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, FIN} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   pout_q, pout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic signed [2*W-1:0] shifted;
    logic [W-1:0]          sat;

    always_comb begin
        shifted = $signed(acc_q) >>> F;
        sat     = shifted[W-1:0];
        if (shifted > MAX_P) begin
            sat = MAX_P[W-1:0];
        end else if (shifted < MIN_N) begin
            sat = MIN_N[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    acc_d   = '0;
                    mcand_d = {{W{A[W-1]}}, A};
                    mplr_d  = B;
                    cnt_d   = CW'(W);
                    busy_d  = 1'b1;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (cnt_q != '0) begin
                    // The sign bit of B carries weight -2^(W-1), so the last step subtracts.
                    if (mplr_q[0]) begin
                        if (cnt_q == CW'(1)) begin
                            acc_d = acc_q - mcand_q;
                        end else begin
                            acc_d = acc_q + mcand_q;
                        end
                    end
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q - CW'(1);
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                pout_d  = sat;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Pout = pout_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
